// File: rtl/beta_pkg.sv
// Shared types for the beta pipeline sequencer: fetch sequencer state encoding.
package beta_pkg;

  typedef enum logic [2:0] {
    REQ   = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    HOLD  = 3'd3,
    FLUSH = 3'd4
  } pcu_fetch_state_t;

endpackage

// File: rtl/beta_pcu_scoreboard.sv
// Register scoreboard tracking outstanding multi-cycle writes; reports RAW source hits,
// WAW conflicts on the decode destination and a full indication.
module beta_pcu_scoreboard
  import beta_pkg::*;
#(
  parameter int RegAddrWidth = 5,
  parameter int MaxPending   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [RegAddrWidth-1:0] rs1_i,
  input  logic [RegAddrWidth-1:0] rs2_i,
  input  logic [1:0]              rs_used_i,
  input  logic [RegAddrWidth-1:0] rd_i,
  input  logic                    wreq_i,
  input  logic                    multi_cycle_i,
  input  logic                    issue_i,
  input  logic                    wb_valid_i,
  input  logic [RegAddrWidth-1:0] wb_rd_i,
  output logic [1:0]              src_o,
  output logic                    waw_o,
  output logic                    full_o
);

  localparam int RegNum = 1 << RegAddrWidth;
  localparam int CntW   = $clog2(MaxPending + 1);

  logic [RegNum-1:0] pending_q, pending_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [RegNum-1:0] set_mask_s, clr_mask_s;
  logic              set_en_s, clr_en_s, set_new_s;

  always_comb begin
    set_en_s   = issue_i & wreq_i & multi_cycle_i & (rd_i != '0);
    clr_en_s   = wb_valid_i & pending_q[wb_rd_i];
    set_mask_s = '0;
    clr_mask_s = '0;
    if (set_en_s) set_mask_s[rd_i] = 1'b1;
    else          set_mask_s = '0;
    if (clr_en_s) clr_mask_s[wb_rd_i] = 1'b1;
    else          clr_mask_s = '0;
    // A set only adds to the count if the bit is not already held after this cycle's clear.
    set_new_s    = set_en_s & (~pending_q[rd_i] | clr_mask_s[rd_i]);
    pending_d    = (pending_q & ~clr_mask_s) | set_mask_s;
    pending_d[0] = 1'b0;
    count_d      = count_q + CntW'(set_new_s) - CntW'(clr_en_s);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    src_o  = {rs_used_i[1] & pending_q[rs2_i], rs_used_i[0] & pending_q[rs1_i]};
    waw_o  = wreq_i & multi_cycle_i & pending_q[rd_i];
    full_o = (count_q == CntW'(MaxPending));
  end

endmodule

// File: rtl/beta_pipeline_sequencer.sv
// Pipeline control for an N-stage in-order pipeline: boundary stall/flush generation,
// single-outstanding fetch sequencer and multi-cycle write scoreboard.
module beta_pipeline_sequencer
  import beta_pkg::*;
#(
  parameter int StageNum     = 3,
  parameter int RegAddrWidth = 5,
  parameter int MaxPending   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [StageNum-1:0]     stage_busy_i,
  output logic                    fetch_en_o,
  output logic [StageNum-2:0]     pip_stall_o,
  output logic [StageNum-2:0]     pip_flush_o,
  input  logic [RegAddrWidth-1:0] dec_rs1_i,
  input  logic [RegAddrWidth-1:0] dec_rs2_i,
  input  logic [1:0]              dec_rs_used_i,
  input  logic [RegAddrWidth-1:0] dec_rd_i,
  input  logic                    dec_wreq_i,
  input  logic                    dec_multi_cycle_i,
  input  logic                    dec_issue_i,
  input  logic                    wb_valid_i,
  input  logic [RegAddrWidth-1:0] wb_rd_i,
  input  logic                    bju_taken_i,
  output logic                    data_hazard_flag_o,
  output logic [1:0]              data_hazard_src_o,
  output logic                    ctrl_hazard_flag_o,
  output logic                    pending_full_o
);

  pcu_fetch_state_t      state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic                  busy0_q, busy0_d;
  logic                  waw_s, hold_dec_s, busy0_fall_s;
  logic [StageNum-2:0]   stall_s, flush_s;

  beta_pcu_scoreboard #(
    .RegAddrWidth (RegAddrWidth),
    .MaxPending   (MaxPending)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rs1_i         (dec_rs1_i),
    .rs2_i         (dec_rs2_i),
    .rs_used_i     (dec_rs_used_i),
    .rd_i          (dec_rd_i),
    .wreq_i        (dec_wreq_i),
    .multi_cycle_i (dec_multi_cycle_i),
    .issue_i       (dec_issue_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .src_o         (data_hazard_src_o),
    .waw_o         (waw_s),
    .full_o        (pending_full_o)
  );

  always_comb begin
    hold_dec_s = (|data_hazard_src_o) | waw_s |
                 (pending_full_o & dec_wreq_i & dec_multi_cycle_i);
    data_hazard_flag_o = hold_dec_s;
    ctrl_hazard_flag_o = bju_taken_i;
  end

  // Stall ripples backwards from execute; decode hazards hold every boundary before decode->execute.
  always_comb begin
    stall_s = '0;
    stall_s[StageNum-2] = stage_busy_i[StageNum-1];
    for (int k = StageNum - 3; k >= 0; k--) begin
      stall_s[k] = stage_busy_i[k+1] | stall_s[k+1] | hold_dec_s;
    end
    flush_s = '0;
    if (rst_i || bju_taken_i) begin
      flush_s = '1;
    end else begin
      flush_s[StageNum-2] = hold_dec_s & ~stage_busy_i[StageNum-1];
      flush_s[0]          = flush_s[0] | (state_q == FLUSH);
    end
    if (rst_i) pip_stall_o = '0;
    else       pip_stall_o = stall_s;
    pip_flush_o = flush_s;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= REQ;
      inflight_q <= 1'b0;
      busy0_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      busy0_q    <= busy0_d;
    end
  end

  // A fetch stays in flight until its busy falls; FLUSH may leave in that same cycle.
  always_comb begin
    busy0_d      = stage_busy_i[0];
    busy0_fall_s = busy0_q & ~stage_busy_i[0];
    if (fetch_en_o)        inflight_d = 1'b1;
    else if (busy0_fall_s) inflight_d = 1'b0;
    else                   inflight_d = inflight_q;
    state_d = state_q;
    if (bju_taken_i) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        REQ:     state_d = START;
        START:   state_d = stage_busy_i[0] ? BUSY : START;
        BUSY:    state_d = stage_busy_i[0] ? BUSY : (stall_s[0] ? HOLD : REQ);
        HOLD:    state_d = stall_s[0] ? HOLD : REQ;
        FLUSH:   state_d = (inflight_q & ~busy0_fall_s) ? FLUSH : REQ;
        default: state_d = REQ;
      endcase
    end
  end

  always_comb begin
    fetch_en_o = (state_q == REQ) & ~rst_i;
  end

endmodule

// File: tb/tb_beta_pipeline_sequencer.sv
// Directed bench for beta_pipeline_sequencer (StageNum 3 and 5 instances) with a
// queue of expected per-cycle results and a 3-cycle fetch-unit responder.
module tb_beta_pipeline_sequencer;

  localparam int W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   busy;
  logic [4:0]   busy5;
  logic [W-1:0] rs1, rs2, rd, wb_rd;
  logic [1:0]   used;
  logic         wreq, multi, issue, wb_valid, bju;

  logic         fetch_en, flag, ctrl, full;
  logic [1:0]   stall, flush, src;
  logic         fetch_en5, flag5, ctrl5, full5;
  logic [3:0]   stall5, flush5;
  logic [1:0]   src5;

  beta_pipeline_sequencer #(.StageNum(3), .RegAddrWidth(W), .MaxPending(4)) dut (
    .clk_i(clk), .rst_i(rst), .stage_busy_i(busy), .fetch_en_o(fetch_en),
    .pip_stall_o(stall), .pip_flush_o(flush), .dec_rs1_i(rs1), .dec_rs2_i(rs2),
    .dec_rs_used_i(used), .dec_rd_i(rd), .dec_wreq_i(wreq), .dec_multi_cycle_i(multi),
    .dec_issue_i(issue), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .bju_taken_i(bju),
    .data_hazard_flag_o(flag), .data_hazard_src_o(src), .ctrl_hazard_flag_o(ctrl),
    .pending_full_o(full)
  );

  beta_pipeline_sequencer #(.StageNum(5), .RegAddrWidth(W), .MaxPending(4)) dut5 (
    .clk_i(clk), .rst_i(rst), .stage_busy_i(busy5), .fetch_en_o(fetch_en5),
    .pip_stall_o(stall5), .pip_flush_o(flush5), .dec_rs1_i(rs1), .dec_rs2_i(rs2),
    .dec_rs_used_i(used), .dec_rd_i(rd), .dec_wreq_i(wreq), .dec_multi_cycle_i(multi),
    .dec_issue_i(issue), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .bju_taken_i(bju),
    .data_hazard_flag_o(flag5), .data_hazard_src_o(src5), .ctrl_hazard_flag_o(ctrl5),
    .pending_full_o(full5)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          bcnt = 0;
  logic        fetch_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  // Advance one clock; the fetch unit holds busy[0] for 3 cycles after each request.
  task automatic cyc();
    fetch_seen = fetch_en;
    @(posedge clk);
    #1;
    if (fetch_seen) bcnt = 3;
    if (bcnt > 0) begin
      busy[0] = 1'b1;
      bcnt--;
    end else begin
      busy[0] = 1'b0;
    end
  endtask

  task automatic dec_idle();
    rs1 = '0; rs2 = '0; rd = '0; used = 2'b00;
    wreq = 1'b0; multi = 1'b0; issue = 1'b0;
  endtask

  task automatic wait_fetch();
    int k = 0;
    #1;
    while (!fetch_en && k < 20) begin
      cyc();
      #1;
      k++;
    end
    check("wait_fetch_seen", fetch_en, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; busy = 3'b000; busy5 = 5'b00000; bju = 1'b0;
    wb_valid = 1'b0; wb_rd = '0;
    dec_idle();

    // Reset cycle: stall forced low even with downstream busy.
    cyc();
    busy[2:1] = 2'b11;
    #1;
    check("rst_fetch_en", fetch_en, 1'b0);
    check("rst_flush", flush, 2'b11);
    check("rst_stall", stall, 2'b00);
    check("rst_full", full, 1'b0);
    check("rst_flush5", flush5, 4'hf);
    check("rst_fetch_en5", fetch_en5, 1'b0);
    check("rst_full5", full5, 1'b0);

    // Fetch rhythm: request every 5 cycles with busy[0] high for 3.
    cyc();
    rst = 1'b0;
    busy[2:1] = 2'b00;
    for (int i = 0; i < 15; i++) push((i % 5 == 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < 15; i++) begin
      #1;
      pop_check("fetch_rhythm", fetch_en);
      cyc();
    end

    // RAW on x5: held until the cycle after its writeback.
    rd = 5'd5; wreq = 1'b1; multi = 1'b1; issue = 1'b1;
    #1;
    check("raw_issue_flag", flag, 1'b0);
    cyc();
    dec_idle();
    rs1 = 5'd5; used = 2'b01;
    push(1); push(1); push(1); push(0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin wb_valid = 1'b1; wb_rd = 5'd5; end
      #1;
      pop_check("raw_flag", flag);
      if (i == 0) begin
        check("raw_src", src, 2'b01);
        check("raw_flush1", flush[1], 1'b1);
        check("raw_stall", stall, 2'b01);
        check("raw_stall5", stall5, 4'b0111);
        check("raw_flush5_3", flush5[3], 1'b1);
        check("raw_flag5", flag5, 1'b1);
        check("raw_src5", src5, 2'b01);
      end
      if (i == 3) begin
        check("raw_rel_src", src, 2'b00);
        check("raw_rel_flush1", flush[1], 1'b0);
      end
      cyc();
      wb_valid = 1'b0;
    end

    // Fill all four pending slots.
    dec_idle();
    for (int i = 1; i <= 4; i++) begin
      rd = W'(i); wreq = 1'b1; multi = 1'b1; issue = 1'b1;
      #1;
      check("fill_flag", flag, 1'b0);
      cyc();
    end
    issue = 1'b0; rd = 5'd9;
    #1;
    check("full_set", full, 1'b1);
    check("full_hold_flag", flag, 1'b1);
    check("full_hold_src", src, 2'b00);
    multi = 1'b0;
    #1;
    check("full_single_not_held", flag, 1'b0);
    multi = 1'b1;
    cyc();
    wb_valid = 1'b1; wb_rd = 5'd20;
    #1;
    check("full_hold2", flag, 1'b1);
    cyc();
    wb_rd = 5'd2;
    #1;
    check("ignored_clear_full", full, 1'b1);
    check("no_bypass_flag", flag, 1'b1);
    cyc();
    wb_rd = 5'd1; issue = 1'b1;
    #1;
    check("after_wb_full", full, 1'b0);
    check("after_wb_flag", flag, 1'b0);
    cyc();
    wb_valid = 1'b0; rd = 5'd11;
    #1;
    check("set_clr_same_cycle_full", full, 1'b0);
    cyc();
    dec_idle();
    #1;
    check("refill_full", full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1;
      wb_rd = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : (i == 2) ? 5'd9 : 5'd11;
      cyc();
    end
    wb_valid = 1'b0;
    #1;
    check("drained_full", full, 1'b0);

    // x0 is never tracked; WAW on x7.
    rd = 5'd0; wreq = 1'b1; multi = 1'b1; issue = 1'b1;
    cyc();
    rd = 5'd7; rs1 = 5'd0; used = 2'b01;
    #1;
    check("x0_not_pending", flag, 1'b0);
    cyc();
    issue = 1'b0; used = 2'b00;
    #1;
    check("waw_flag", flag, 1'b1);
    check("waw_src", src, 2'b00);
    multi = 1'b0;
    #1;
    check("waw_single_cycle", flag, 1'b0);

    // Reset while decode is held on x7.
    dec_idle();
    rs1 = 5'd7; used = 2'b01;
    #1;
    check("pre_rst_flag", flag, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_flush", flush, 2'b11);
    check("mid_rst_fetch_en", fetch_en, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    check("post_rst_flag", flag, 1'b0);
    check("post_rst_fetch_en", fetch_en, 1'b1);
    dec_idle();

    // Taken branch in BUSY.
    cyc();
    wait_fetch();
    cyc();
    cyc();
    bju = 1'b1;
    #1;
    check("bju_busy_flush", flush, 2'b11);
    check("bju_ctrl", ctrl, 1'b1);
    check("bju_flush5", flush5, 4'hf);
    check("bju_ctrl5", ctrl5, 1'b1);
    cyc();
    bju = 1'b0;
    #1;
    check("flush_wait_f0", flush[0], 1'b1);
    check("flush_wait_fetch", fetch_en, 1'b0);
    cyc();
    #1;
    check("flush_fall_f0", flush[0], 1'b1);
    check("flush_fall_fetch", fetch_en, 1'b0);
    cyc();
    #1;
    check("refetch", fetch_en, 1'b1);
    check("refetch_flush", flush, 2'b00);

    // Taken branch in the REQ cycle: waits for that fetch to finish.
    bju = 1'b1;
    #1;
    check("bju_req_flush", flush, 2'b11);
    push(0); push(0); push(0); push(0); push(1);
    cyc();
    bju = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      pop_check("bju_req_refetch", fetch_en);
      cyc();
    end

    // Five-stage stall chain.
    busy5 = 5'b10000;
    #1;
    check("stall5_exec_busy", stall5, 4'b1111);
    busy5 = 5'b00100;
    #1;
    check("stall5_mid_busy", stall5, 4'b0011);
    busy5 = 5'b00000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/beta_pipeline_sequencer.md
# beta_pipeline_sequencer

Parametrised successor of the pipeline control unit for an N-stage in-order pipeline. Generates per-boundary stall/flush, a one-instruction-in-flight fetch sequencer, and a register scoreboard that tracks multiple outstanding multi-cycle writes (RAW and WAW). Taken branches/jumps flush the wrong path and restart fetch. Sits beside the datapath, between fetch, decode, execute and writeback.

## Interface
Parameters:
- StageNum, 3, pipeline stages (>=3); stage 0 fetch, StageNum-2 decode, StageNum-1 execute
- RegAddrWidth, 5, register index width
- MaxPending, 4, max outstanding multi-cycle writes (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- stage_busy_i  in  StageNum  per-stage busy; bit0 fetch
- fetch_en_o  out  1  one-cycle fetch request
- pip_stall_o  out  StageNum-1  bit k holds register between stage k and k+1
- pip_flush_o  out  StageNum-1  bit k clears that register (overrides stall)
- dec_rs1_i, dec_rs2_i  in  RegAddrWidth  decode sources
- dec_rs_used_i  in  2  bit0 rs1 read, bit1 rs2 read
- dec_rd_i  in  RegAddrWidth  decode destination
- dec_wreq_i  in  1  decode instruction writes rd
- dec_multi_cycle_i  in  1  decode instruction is multi-cycle
- dec_issue_i  in  1  decode->execute register captures this cycle
- wb_valid_i  in  1  multi-cycle write completes
- wb_rd_i  in  RegAddrWidth  completing destination
- bju_taken_i  in  1  branch/jump taken, one-cycle pulse
- data_hazard_flag_o  out  1  decode held by scoreboard
- data_hazard_src_o  out  2  bit0 rs1 hit, bit1 rs2 hit
- ctrl_hazard_flag_o  out  1  equals bju_taken_i
- pending_full_o  out  1  pending count == MaxPending

## Operation
- Scoreboard: pending bitmask of 2^RegAddrWidth bits plus count. Set bit dec_rd_i when dec_issue_i & dec_wreq_i & dec_multi_cycle_i & rd!=0. Clear bit wb_rd_i on wb_valid_i if set; clear of non-pending bit ignored. Set and clear of different regs same cycle: count unchanged. Reg 0 never pending.
- data_hazard_src_o = {used[1]&pend[rs2], used[0]&pend[rs1]}; WAW = dec_wreq_i & dec_multi_cycle_i & pend[rd]; hold_dec = |src | WAW | (pending_full_o & dec_wreq_i & dec_multi_cycle_i). data_hazard_flag_o = hold_dec.
- Stall: stall[StageNum-2] = busy[StageNum-1]; stall[k] = busy[k+1] | stall[k+1] | (hold_dec & k<=StageNum-3).
- Bubble: hold_dec & ~busy[StageNum-1] -> flush[StageNum-2]=1.
- Control hazard: bju_taken_i -> flush[k]=1 for all k, same cycle; fetch FSM -> FLUSH.
- Fetch FSM (inflight flag set with fetch_en_o, cleared when busy[0] falls):
  - REQ: fetch_en_o=1 -> START.
  - START: busy[0] -> BUSY.
  - BUSY: ~busy[0] & ~stall[0] -> REQ; ~busy[0] & stall[0] -> HOLD.
  - HOLD: ~stall[0] -> REQ.
  - FLUSH: flush[0]=1 each cycle; ~inflight -> REQ.
  - bju_taken_i in any state -> FLUSH, priority over all transitions.

## Timing
- Reset: fetch_en_o=0, pip_flush_o all 1, pip_stall_o 0, scoreboard empty, FSM REQ next cycle (first fetch_en_o 1 cycle after rst_i drops).
- hazard/stall/flush outputs combinational from inputs and registered state; scoreboard updates visible next cycle.
- wb clear on cycle N: decode released at N+1 (no same-cycle bypass).
- bju_taken_i in REQ cycle: inflight set; FLUSH waits for that fetch's busy fall, new fetch_en_o one cycle later.
- Reset mid-operation: all state discarded within the reset cycle.

## Structure
- beta_pkg: typedef enum pcu_fetch_state_t {REQ, START, BUSY, HOLD, FLUSH}.
- Sub-module beta_pcu_scoreboard: bitmask, count, src/WAW/full outputs.

## Test plan
- Reset, idle stages: fetch_en_o pulses 1 cycle after reset release, then START/BUSY/REQ loop with busy[0] high 3 cycles -> fetch_en_o every 5 cycles.
- Issue multi-cycle write x5, next decode reads rs1=x5 -> data_hazard_flag_o=1, src=01, flush[1]=1, stall[0]=1; wb_valid_i x5 on N -> released N+1.
- Four multi-cycle writes x1..x4 outstanding, MaxPending=4 -> pending_full_o=1, fifth multi-cycle write held; one wb -> issues.
- WAW: x7 pending, decode multi-cycle write x7, no sources -> flag=1, src=00.
- bju_taken_i during BUSY -> all flush bits 1 that cycle, flush[0] held until busy[0] falls, fetch_en_o next cycle.
- StageNum=5, busy[4]=1 -> pip_stall_o=4'b1111; rst_i mid-hazard -> flag=0 next cycle.
